ycr_wb2dmem: RTL
================

# ycr_wb2dmem

Wishbone-to-DMEM initiator bridge. Accepts single classic Wishbone slave cycles from the SoC side and replays each one as a core-style DMEM transaction (req/req_ack request phase, then resp phase) toward the TCM router's dmem port. It lets an external Wishbone master, such as a debug or boot loader, read and write TCM. It also translates Wishbone byte selects into DMEM width/offset and realigns read data.

## Interface
Parameters:
- REQ_TIMEOUT, 255: maximum cycles `dmem_req` is held without `dmem_req_ack` before the bridge abandons the request with a Wishbone error (8-bit counter).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  1 = write
- wbs_adr_i  in  32  byte address; bits [1:0] ignored
- wbs_dat_i  in  32  write data, lane-aligned
- wbs_sel_i  in  4  byte-lane selects
- wbs_dat_o  out  32  read data, lane-aligned
- wbs_ack_o  out  1  one-cycle transfer-complete pulse
- wbs_err_o  out  1  one-cycle error pulse
- dmem_req  out  1  request valid
- dmem_cmd  out  1  0 = read, 1 = write
- dmem_width  out  2  YCR_MEM_WIDTH_BYTE / HWORD / WORD
- dmem_addr  out  `YCR_DMEM_AWIDTH  byte address including offset
- dmem_wdata  out  `YCR_DMEM_DWIDTH  write data, right-aligned (LSB-justified)
- dmem_req_ack  in  1  request accepted (may be combinational on `dmem_req`)
- dmem_rdata  in  `YCR_DMEM_DWIDTH  read data, right-aligned by responder
- dmem_resp  in  2  YCR_MEM_RESP_NOTRDY / RDY_OK / RDY_ER

Clock and reset: one clock (`clk`); reset `rst_n` is asynchronous and active-low.

## Operation
- States: IDLE, REQ, RESP, DONE.
- **IDLE**
  - On `wbs_cyc_i & wbs_stb_i`, decode `wbs_sel_i`:
    - 0001 / 0010 / 0100 / 1000 -> BYTE, offset 0 / 1 / 2 / 3.
    - 0011 -> HWORD, offset 0.
    - 1100 -> HWORD, offset 2.
    - 1111 -> WORD, offset 0.
  - Legal select: register `dmem_cmd` = `wbs_we_i` and `dmem_width`. Register `dmem_addr` = {wbs_adr_i[AW-1:2], offset}. Register `dmem_wdata` = `wbs_dat_i` >> (8*offset). Set `dmem_req`=1, clear timeout counter, go to REQ.
  - Any other select (including 0000): no DMEM activity; pulse `wbs_err_o`; go to DONE.
- **REQ**
  - Hold `dmem_req` and all request fields stable.
  - On `dmem_req_ack`: drop `dmem_req` next cycle; go to RESP.
  - If `wbs_cyc_i` drops before the ack: drop `dmem_req`; go to IDLE with no ack.
  - If the counter reaches REQ_TIMEOUT: drop `dmem_req`; pulse `wbs_err_o`; go to DONE.
- **RESP**
  - `dmem_resp` is sampled only in this state. There is no timeout here, because the responder has already committed.
  - RDY_OK: capture `wbs_dat_o` = `dmem_rdata` << (8*offset) for reads (writes leave `wbs_dat_o` unchanged); pulse `wbs_ack_o`; go to DONE.
  - RDY_ER: pulse `wbs_err_o`; go to DONE.
  - NOTRDY: stay.
  - If `wbs_cyc_i` dropped while in RESP: the DMEM transaction still completes, but the ack/err pulse is suppressed. An abort flag is captured and cleared in IDLE.
- **DONE**: one cycle, during which ack/err is high. Go to IDLE unconditionally. This gives the master a cycle to deassert or change `wbs_stb_i`.
- `wbs_ack_o` and `wbs_err_o` are never high together. Each is high for exactly one cycle per accepted strobe.

## Timing
- Reset values:
  - `dmem_req`, `dmem_cmd`, `wbs_ack_o`, `wbs_err_o` = 0.
  - `dmem_width` = 0; `dmem_addr`, `dmem_wdata`, `wbs_dat_o` = 0.
  - State IDLE; counter 0; abort flag 0.
- All outputs are registered.
- Strobe sampled at edge E0 -> `dmem_req` high in cycle E0+1.
- With same-cycle `dmem_req_ack` and resp RDY_OK k cycles later, `wbs_ack_o` is high in cycle E0+2+k.
- Write with the router (resp the cycle after ack): ack at E0+3. Read (resp 3 cycles after ack): ack at E0+5.
- Illegal select: `wbs_err_o` at E0+1.
- Reset mid-transaction: immediate return to IDLE. All outputs go to reset values asynchronously.
- A strobe still asserted in the cycle after DONE is treated as a new transfer.

## Test plan
- **Word write then read:** sel=1111, adr=0x104, dat=0xA5A5_1234.
  - Write expects `dmem_cmd`=1, width WORD, `dmem_addr`=0x104, ack at E0+3.
  - Read-back expects `wbs_dat_o`=0xA5A5_1234, ack at E0+5.
- **Byte lanes:** write sel=0100, dat=0x00CD_0000 -> width BYTE, `dmem_addr`[1:0]=2, `dmem_wdata`[7:0]=0xCD. Responder returns rdata=0xCD -> `wbs_dat_o`=0x00CD_0000.
- **Halfword high:** sel=1100, read, responder rdata=0xBEEF -> width HWORD, addr[1:0]=2, `wbs_dat_o`=0xBEEF_0000.
- **Illegal select:** sel=0101 -> no `dmem_req`, `wbs_err_o` one cycle at E0+1, `wbs_ack_o` stays 0.
- **Responder stall, error, timeout:** hold `dmem_req_ack`=0 -> `dmem_req` drops and `wbs_err_o` pulses after 255 cycles. Separately, resp=RDY_ER -> `wbs_err_o` pulses, no ack.
- **Aborts:** drop `wbs_cyc_i` in REQ -> `dmem_req` drops next cycle, no ack/err. Drop it in RESP -> wait for RDY_OK, no ack/err, return to IDLE. Assert `rst_n`=0 in RESP -> all outputs 0 immediately.

Source files
------------

// File: rtl/ycr_wb2dmem.sv
// ycr_wb2dmem: Wishbone classic slave to core-style DMEM initiator bridge.
// Replays one Wishbone cycle as a DMEM req/ack + resp transaction, converting
// byte selects into width/offset and realigning write and read data.
`timescale 1ns/1ps

`ifndef YCR_DMEM_AWIDTH
`define YCR_DMEM_AWIDTH 32
`endif
`ifndef YCR_DMEM_DWIDTH
`define YCR_DMEM_DWIDTH 32
`endif

module ycr_wb2dmem #(
  parameter int unsigned REQ_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wbs_cyc_i,
  input  logic                          wbs_stb_i,
  input  logic                          wbs_we_i,
  input  logic [31:0]                   wbs_adr_i,
  input  logic [31:0]                   wbs_dat_i,
  input  logic [3:0]                    wbs_sel_i,
  output logic [31:0]                   wbs_dat_o,
  output logic                          wbs_ack_o,
  output logic                          wbs_err_o,
  output logic                          dmem_req,
  output logic                          dmem_cmd,
  output logic [1:0]                    dmem_width,
  output logic [`YCR_DMEM_AWIDTH-1:0]   dmem_addr,
  output logic [`YCR_DMEM_DWIDTH-1:0]   dmem_wdata,
  input  logic                          dmem_req_ack,
  input  logic [`YCR_DMEM_DWIDTH-1:0]   dmem_rdata,
  input  logic [1:0]                    dmem_resp
);

  localparam int AW = `YCR_DMEM_AWIDTH;
  localparam int DW = `YCR_DMEM_DWIDTH;

  localparam logic [1:0] WIDTH_BYTE  = 2'b00;
  localparam logic [1:0] WIDTH_HWORD = 2'b01;
  localparam logic [1:0] WIDTH_WORD  = 2'b10;

  localparam logic [1:0] RESP_OK = 2'b01;
  localparam logic [1:0] RESP_ER = 2'b10;

  // Last count value before the request is abandoned (request held REQ_TIMEOUT cycles)
  localparam logic [7:0] CNT_LAST = 8'(REQ_TIMEOUT - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t r_state, w_state;
  logic [7:0]    r_cnt, w_cnt;
  logic          r_abort, w_abort;
  logic [1:0]    r_off, w_off;
  logic          w_req, w_cmd, w_ack, w_err;
  logic [1:0]    w_width;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic [31:0]   w_dat;
  logic [4:0]    w_dec;
  logic [1:0]    w_unused_adr;

  // Map a byte-select pattern to {legal, width, offset}
  function automatic logic [4:0] sel_decode(input logic [3:0] sel);
    logic [4:0] d;
    case (sel)
      4'b0001: d = {1'b1, WIDTH_BYTE,  2'd0};
      4'b0010: d = {1'b1, WIDTH_BYTE,  2'd1};
      4'b0100: d = {1'b1, WIDTH_BYTE,  2'd2};
      4'b1000: d = {1'b1, WIDTH_BYTE,  2'd3};
      4'b0011: d = {1'b1, WIDTH_HWORD, 2'd0};
      4'b1100: d = {1'b1, WIDTH_HWORD, 2'd2};
      4'b1111: d = {1'b1, WIDTH_WORD,  2'd0};
      default: d = {1'b0, WIDTH_BYTE,  2'd0};
    endcase
    return d;
  endfunction

  assign w_dec        = sel_decode(wbs_sel_i);
  assign w_unused_adr = wbs_adr_i[1:0];

  // Next-state and next-output logic; every register holds unless changed below
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_abort = r_abort;
    w_off   = r_off;
    w_req   = dmem_req;
    w_cmd   = dmem_cmd;
    w_width = dmem_width;
    w_addr  = dmem_addr;
    w_wdata = dmem_wdata;
    w_dat   = wbs_dat_o;
    w_ack   = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_abort = 1'b0;
        if (wbs_cyc_i && wbs_stb_i) begin
          if (w_dec[4]) begin
            w_cmd   = wbs_we_i;
            w_width = w_dec[3:2];
            w_off   = w_dec[1:0];
            w_addr  = {wbs_adr_i[AW-1:2], w_dec[1:0]};
            w_wdata = DW'(wbs_dat_i >> {w_dec[1:0], 3'b000});
            w_req   = 1'b1;
            w_cnt   = 8'd0;
            w_state = ST_REQ;
          end else begin
            w_err   = 1'b1;
            w_state = ST_DONE;
          end
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dmem_req_ack) begin
          // Responder has committed; a late cycle drop is remembered as an abort
          w_req   = 1'b0;
          w_abort = ~wbs_cyc_i;
          w_state = ST_RESP;
        end else if (!wbs_cyc_i) begin
          w_req   = 1'b0;
          w_state = ST_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_req   = 1'b0;
          w_err   = 1'b1;
          w_state = ST_DONE;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      ST_RESP: begin
        w_abort = r_abort | ~wbs_cyc_i;
        case (dmem_resp)
          RESP_OK: begin
            if (!w_abort) begin
              if (!dmem_cmd) begin
                w_dat = 32'(dmem_rdata << {r_off, 3'b000});
              end else begin
                w_dat = wbs_dat_o;
              end
              w_ack   = 1'b1;
              w_state = ST_DONE;
            end else begin
              w_state = ST_IDLE;
            end
          end
          RESP_ER: begin
            if (!w_abort) begin
              w_err   = 1'b1;
              w_state = ST_DONE;
            end else begin
              w_state = ST_IDLE;
            end
          end
          default: w_state = ST_RESP;
        endcase
      end
      ST_DONE: w_state = ST_IDLE;
      default: w_state = ST_IDLE;
    endcase
  end

  // State register and registered outputs, cleared asynchronously by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 8'd0;
      r_abort    <= 1'b0;
      r_off      <= 2'd0;
      dmem_req   <= 1'b0;
      dmem_cmd   <= 1'b0;
      dmem_width <= 2'd0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      wbs_dat_o  <= 32'd0;
      wbs_ack_o  <= 1'b0;
      wbs_err_o  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_abort    <= w_abort;
      r_off      <= w_off;
      dmem_req   <= w_req;
      dmem_cmd   <= w_cmd;
      dmem_width <= w_width;
      dmem_addr  <= w_addr;
      dmem_wdata <= w_wdata;
      wbs_dat_o  <= w_dat;
      wbs_ack_o  <= w_ack;
      wbs_err_o  <= w_err;
    end
  end

endmodule
